// File: rtl/vproc_mem_pkg.sv
// ============================================================================
// vproc_mem_pkg : shared helpers for the vproc fixed-latency memory model
// Rev 1.0
// ============================================================================
`default_nettype none

package vproc_mem_pkg;

   // Range check plus unmasked word offset of a byte address inside the window
   typedef struct packed {
      logic        err;
      logic [31:0] word;
   } addr_dec_t;

   function automatic addr_dec_t addr_decode(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] mem_sz,
      input int unsigned wb_log2
   );
      addr_dec_t   r;
      logic [31:0] off;
      off    = addr - base;
      r.err  = (addr < base) || (off >= mem_sz);
      r.word = off >> wb_log2;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vproc_rr_arbiter.sv
// ============================================================================
// vproc_rr_arbiter : round-robin arbiter with combinational one-hot grant
// Rev 1.0
// ============================================================================
`default_nettype none

module vproc_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   input  logic             accept_en_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] p_idx;
   logic             found;
   int               p;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      p         = 0;
      p_idx     = '0;
      for (int k = 0; k < N; k++) begin
         p = int'(rr_ptr_q) + k;
         if (p >= N) p = p - N;
         p_idx = IDX_W'(p);
         if (accept_en_i && !found && req_i[p_idx]) begin
            found          = 1'b1;
            gnt_o[p_idx]   = 1'b1;
            gnt_idx_o      = p_idx;
         end
      end
   end

   // Grants only go to requesting ports, so any grant is an accept
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (|gnt_o) begin
         rr_ptr_d = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

endmodule

`default_nettype wire

// File: rtl/vproc_lat_mem.sv
// ============================================================================
// vproc_lat_mem : multi-port fixed-latency memory model with backdoor preload
// Rev 1.0
// ============================================================================
`default_nettype none

module vproc_lat_mem
   import vproc_mem_pkg::*;
#(
   parameter int          NUM_PORTS = 2,
   parameter int          MEM_W     = 32,
   parameter int          MEM_SZ    = 262144,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0]                  req_i,
   output logic [NUM_PORTS-1:0]                  gnt_o,
   input  logic [NUM_PORTS*32-1:0]               addr_i,
   input  logic [NUM_PORTS-1:0]                  we_i,
   input  logic [NUM_PORTS*MEM_W/8-1:0]          be_i,
   input  logic [NUM_PORTS*MEM_W-1:0]            wdata_i,
   output logic [NUM_PORTS-1:0]                  rvalid_o,
   output logic [NUM_PORTS-1:0]                  err_o,
   output logic [NUM_PORTS*MEM_W-1:0]            rdata_o,
   input  logic                                  bd_we_i,
   input  logic [$clog2(MEM_SZ/(MEM_W/8))-1:0]   bd_idx_i,
   input  logic [MEM_W-1:0]                      bd_wdata_i
);

   localparam int          WB      = MEM_W / 8;
   localparam int unsigned WB_LOG2 = $clog2(WB);
   localparam int          DEPTH   = MEM_SZ / WB;
   localparam int          IDX_W   = $clog2(DEPTH);
   localparam int          PID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef struct packed {
      logic             valid;
      logic [PID_W-1:0] port;
      logic             err;
      logic [MEM_W-1:0] data;
   } resp_entry_t;

   logic [MEM_W-1:0] mem [DEPTH];

   logic [31:0]      addr_a  [NUM_PORTS];
   logic [WB-1:0]    be_a    [NUM_PORTS];
   logic [MEM_W-1:0] wdata_a [NUM_PORTS];

   logic [PID_W-1:0] gnt_idx;
   logic             accept;
   logic             sel_we;
   logic [WB-1:0]    sel_be;
   logic [MEM_W-1:0] sel_wdata;
   addr_dec_t        dec;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;

   resp_entry_t      entry_new;
   resp_entry_t      pipe_q [LATENCY];
   resp_entry_t      resp;
   logic [NUM_PORTS-1:0]       hit;
   logic [NUM_PORTS*MEM_W-1:0] rdata_q;

   for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
      assign addr_a[gp]  = addr_i[gp*32 +: 32];
      assign be_a[gp]    = be_i[gp*WB +: WB];
      assign wdata_a[gp] = wdata_i[gp*MEM_W +: MEM_W];
   end

   vproc_rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (PID_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .accept_en_i (!rst && !bd_we_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx)
   );

   assign accept    = |gnt_o;
   assign sel_we    = we_i[gnt_idx];
   assign sel_be    = be_a[gnt_idx];
   assign sel_wdata = wdata_a[gnt_idx];
   assign dec       = addr_decode(addr_a[gnt_idx], BASE_ADDR, 32'(MEM_SZ), WB_LOG2);

   // Upper word bits are zero whenever the window check passes
   assign acc_err = dec.err | (|dec.word[31:IDX_W]);
   assign acc_idx = dec.word[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (bd_we_i) begin
         mem[bd_idx_i] <= bd_wdata_i;
      end else if (accept && sel_we && !acc_err) begin
         for (int b = 0; b < WB; b++) begin
            if (sel_be[b]) mem[acc_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      entry_new       = '0;
      entry_new.valid = accept;
      entry_new.port  = gnt_idx;
      entry_new.err   = acc_err;
      entry_new.data  = (accept && !sel_we && !acc_err) ? mem[acc_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) pipe_q[s] <= '0;
      end else begin
         pipe_q[0] <= entry_new;
         for (int s = 1; s < LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign resp = pipe_q[LATENCY-1];

   for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_resp
      assign hit[gp]      = resp.valid && !rst && (resp.port == PID_W'(gp));
      assign rvalid_o[gp] = hit[gp];
      assign err_o[gp]    = hit[gp] & resp.err;
      assign rdata_o[gp*MEM_W +: MEM_W] = hit[gp] ? resp.data : rdata_q[gp*MEM_W +: MEM_W];
   end

   // Idle ports keep presenting their last response data
   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_o;
   end

endmodule

`default_nettype wire
